// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port among NUM_REQ producers in bursts.
// Optional macro FIFO_ARB_TIMEOUT_EN adds an 8-cycle stall abort while a burst is in progress.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          sclr,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          fifo_wr_en,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IdxW-1:0]    last_idx_q, last_idx_d;
  logic [CntW-1:0]    beat_cnt_q, beat_cnt_d;

  logic            gnt_valid, gnt_last, win_found;
  logic [IdxW-1:0] win_idx;

  assign grant = grant_q;
  assign busy  = (state_q == StBurst);

  always_comb begin
    gnt_valid = |(grant_q & req_valid);
    gnt_last  = |(grant_q & req_last);
    fifo_din  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) fifo_din = fifo_din | req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    req_ready  = (busy && !sclr && !fifo_full) ? grant_q : '0;
    fifo_wr_en = |(req_valid & req_ready);
  end

  // Search starts one past the last winner so the previous grantee goes last.
  always_comb begin
    int unsigned idx_w;
    logic [IdxW-1:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx_w     = 0;
    idx       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx_w = (32'(last_idx_q) + k) % NUM_REQ;
      idx   = IdxW'(idx_w);
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

`ifdef FIFO_ARB_TIMEOUT_EN
  logic [3:0] stall_cnt_q, stall_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_idx_d = last_idx_q;
    beat_cnt_d = beat_cnt_q;
`ifdef FIFO_ARB_TIMEOUT_EN
    stall_cnt_d = stall_cnt_q;
`endif
    case (state_q)
      StIdle: begin
`ifdef FIFO_ARB_TIMEOUT_EN
        stall_cnt_d = '0;
`endif
        if (!fifo_almost_full && win_found) begin
          state_d          = StBurst;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          last_idx_d       = win_idx;
          beat_cnt_d       = '0;
        end
      end
      StBurst: begin
        if (fifo_wr_en) begin
`ifdef FIFO_ARB_TIMEOUT_EN
          stall_cnt_d = '0;
`endif
          if (gnt_last || (beat_cnt_q == CntW'(MAX_BURST - 1))) begin
            state_d    = StIdle;
            grant_d    = '0;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CntW'(1);
          end
        end
`ifdef FIFO_ARB_TIMEOUT_EN
        else if (!gnt_valid && !fifo_full) begin
          if (stall_cnt_q == 4'd7) begin
            state_d     = StIdle;
            grant_d     = '0;
            beat_cnt_d  = '0;
            stall_cnt_d = '0;
          end else begin
            stall_cnt_d = stall_cnt_q + 4'd1;
          end
        end
`endif
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      last_idx_q <= IdxW'(NUM_REQ - 1);
      beat_cnt_q <= '0;
`ifdef FIFO_ARB_TIMEOUT_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_idx_q <= last_idx_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef FIFO_ARB_TIMEOUT_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

endmodule
